// File: rtl/ahb_bm_pkg.sv
// Shared AHB bus-matrix encodings and the address-phase control bundle.
package ahb_bm_pkg;

   typedef enum logic [1:0] {
      TRN_IDLE   = 2'b00,
      TRN_BUSY   = 2'b01,
      TRN_NONSEQ = 2'b10,
      TRN_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      BRST_SINGLE = 3'b000,
      BRST_INCR   = 3'b001,
      BRST_WRAP4  = 3'b010,
      BRST_INCR4  = 3'b011,
      BRST_WRAP8  = 3'b100,
      BRST_INCR8  = 3'b101,
      BRST_WRAP16 = 3'b110,
      BRST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic {
      RSP_OKAY  = 1'b0,
      RSP_ERROR = 1'b1
   } hresp_e;

   typedef struct packed {
      logic       write;
      logic [2:0] size;
      logic [2:0] burst;
      logic [3:0] prot;
      logic       lock;
   } ctrl_t;

   // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
   function automatic logic is_active_trans(input logic [1:0] trans);
      return trans[1];
   endfunction

endpackage

// File: rtl/ahb_is_hold_reg.sv
// Address-phase holding register with replay mux: bypass is combinational, i_use_held selects the stored copy.
// Lock bit is only stored when AHB_IS_MASTLOCK_EN is defined; otherwise it reads as 0.
module ahb_is_hold_reg
   import ahb_bm_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_use_held,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [1:0]            i_trans,
   input  ctrl_t                 i_ctrl,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [1:0]            o_trans,
   output ctrl_t                 o_ctrl
);

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_trans;
   ctrl_t                 r_ctrl;
   ctrl_t                 w_ctrl_live;

`ifdef AHB_IS_MASTLOCK_EN
   assign w_ctrl_live = i_ctrl;
`else
   always_comb begin
      w_ctrl_live      = i_ctrl;
      w_ctrl_live.lock = 1'b0;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_trans <= TRN_IDLE;
         r_ctrl  <= '0;
      end else if (i_load) begin
         r_addr  <= i_addr;
         r_trans <= i_trans;
         r_ctrl  <= w_ctrl_live;
      end
   end

   assign o_addr  = i_use_held ? r_addr  : i_addr;
   assign o_trans = i_use_held ? r_trans : i_trans;
   assign o_ctrl  = i_use_held ? r_ctrl  : w_ctrl_live;

endmodule

// File: rtl/ahb_input_stage.sv
// Per-master AHB input stage: passes a granted transfer through with zero latency, holds and replays a denied one
// while stalling the master, and routes slave HREADYOUT/HRESP back. Lock forwarding needs AHB_IS_MASTLOCK_EN.
module ahb_input_stage
   import ahb_bm_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSELS,
   input  logic [ADDR_WIDTH-1:0] HADDRS,
   input  logic [1:0]            HTRANSS,
   input  logic                  HWRITES,
   input  logic [2:0]            HSIZES,
   input  logic [2:0]            HBURSTS,
   input  logic [3:0]            HPROTS,
   input  logic                  HMASTLOCKS,
   input  logic                  HREADYS,
   output logic                  HREADYOUTS,
   output logic                  HRESPS,
   output logic                  sel_dec,
   output logic [ADDR_WIDTH-1:0] addr_dec,
   output logic [1:0]            trans_dec,
   output logic                  write_dec,
   output logic [2:0]            size_dec,
   output logic [2:0]            burst_dec,
   output logic [3:0]            prot_dec,
   output logic                  mastlock_dec,
   input  logic                  active_dec,
   input  logic                  readyout_dec,
   input  logic                  resp_dec
);

   logic       r_pend_tran;
   logic       r_data_phase;
   logic       w_new_tran;
   logic       w_accepted;
   logic       w_load;
   logic [1:0] w_trans;
   ctrl_t      w_ctrl_in;
   ctrl_t      w_ctrl_out;

   assign w_new_tran = HSELS & HREADYS & is_active_trans(HTRANSS);
   assign sel_dec    = r_pend_tran | w_new_tran;
   assign w_accepted = sel_dec & active_dec & readyout_dec;
   // A pending transfer is never overwritten, even by an (illegal) new one.
   assign w_load     = w_new_tran & ~r_pend_tran;
   assign w_ctrl_in  = {HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};

   ahb_is_hold_reg #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_hold (
      .clk        (HCLK),
      .rst        (HRESET),
      .i_load     (w_load),
      .i_use_held (r_pend_tran),
      .i_addr     (HADDRS),
      .i_trans    (HTRANSS),
      .i_ctrl     (w_ctrl_in),
      .o_addr     (addr_dec),
      .o_trans    (w_trans),
      .o_ctrl     (w_ctrl_out)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_pend_tran  <= 1'b0;
         r_data_phase <= 1'b0;
      end else begin
         if (w_accepted)
            r_pend_tran <= 1'b0;
         else if (w_new_tran)
            r_pend_tran <= 1'b1;

         if (w_accepted)
            r_data_phase <= 1'b1;
         else if (readyout_dec)
            r_data_phase <= 1'b0;
      end
   end

   assign trans_dec    = sel_dec ? w_trans : TRN_IDLE;
   assign write_dec    = w_ctrl_out.write;
   assign size_dec     = w_ctrl_out.size;
   assign burst_dec    = w_ctrl_out.burst;
   assign prot_dec     = w_ctrl_out.prot;
   assign mastlock_dec = w_ctrl_out.lock;

   assign HREADYOUTS = r_pend_tran ? 1'b0 : (r_data_phase ? readyout_dec : 1'b1);
   assign HRESPS     = r_data_phase ? resp_dec : RSP_OKAY;

endmodule
